// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits (LSB first), parity bit, stop bit.
// Holds one received word with parity/framing flags, flags overruns and counts bad frames.
module parity_frame_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              par_err,
    output logic              frame_err,
    output logic              overrun,
    output logic [7:0]        err_cnt,
    input  logic              clr_cnt,
    output logic              busy
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_bit_q, par_bit_d;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              par_err_q, par_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              frame_done;
    logic              load;
    logic              drop;
    logic              new_par_err;
    logic              new_frame_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
        end
    end

    // Next-state and receive datapath
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!ser_in) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    shreg_d[cnt_q] = ser_in;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    par_bit_d = ser_in;
                    state_d   = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode: frame evaluation on the stop-bit strobe
    always_comb begin
        busy          = (state_q != S_IDLE);
        frame_done    = (state_q == S_STOP) && bit_en;
        new_par_err   = ((^shreg_q) ^ par_bit_q) != ODD;
        new_frame_err = ~ser_in;
        load          = frame_done && (!out_valid_q || out_ready);
        drop          = frame_done && out_valid_q && !out_ready;
    end

    // Held word: a load in the handshake cycle wins over the clear of out_valid
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (load) begin
            out_data_d  = shreg_q;
            out_valid_d = 1'b1;
            par_err_d   = new_par_err;
            frame_err_d = new_frame_err;
        end else if (drop) begin
            overrun_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (frame_done && (drop || new_par_err || new_frame_err)
                     && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign par_err   = par_err_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an even-parity instance with a driven consumer and
// an odd-parity instance that always accepts, both fed from the same serial line.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       ser_in = 1'b1;
    logic       out_ready = 1'b0;
    logic       clr_cnt = 1'b0;

    logic [7:0] out_data;
    logic       out_valid, par_err, frame_err, overrun, busy;
    logic [7:0] err_cnt;

    logic [7:0] o_out_data;
    logic       o_out_valid, o_par_err, o_frame_err, o_overrun, o_busy;
    logic [7:0] o_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .ser_in(ser_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .par_err(par_err), .frame_err(frame_err), .overrun(overrun),
        .err_cnt(err_cnt), .clr_cnt(clr_cnt), .busy(busy)
    );

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .ser_in(ser_in),
        .out_data(o_out_data), .out_valid(o_out_valid), .out_ready(1'b1),
        .par_err(o_par_err), .frame_err(o_frame_err), .overrun(o_overrun),
        .err_cnt(o_err_cnt), .clr_cnt(clr_cnt), .busy(o_busy)
    );

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // One strobed bit followed by one idle cycle; rdy is out_ready during the strobe
    task automatic send_bit(input logic b, input logic rdy);
        @(negedge clk);
        ser_in = b; bit_en = 1'b1; out_ready = rdy;
        @(negedge clk);
        bit_en = 1'b0; ser_in = 1'b1; out_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic rdy);
        logic [10:0] f;
        f = frame_bits(d, p, s);
        for (int i = 0; i < 11; i++) send_bit(f[i], (i == 10) ? rdy : 1'b0);
    endtask

    task automatic consume();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL consume_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", out_data); end
        n_checks++; if ({par_err, frame_err, overrun, busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {par_err, frame_err, overrun, busy}); end
        n_checks++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", err_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [10:0] f;
        f = frame_bits(8'hA5, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) send_bit(f[i], 1'b0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %b expected 1", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid: got %b expected 0", out_valid); end
        send_bit(f[10], 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL good_data: got %h expected a5", out_data); end
        n_checks++; if ({par_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL good_errs: got %b expected 00", {par_err, frame_err}); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL good_cnt: got %0d expected 0", err_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_idle: got %b expected 0", busy); end
        n_checks++; if (o_par_err !== 1'b1) begin n_fail++; $display("FAIL good_odd_par: got %b expected 1", o_par_err); end
        // held word must not change while waiting for the consumer
        repeat (3) @(negedge clk);
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL good_hold: got %b/%h expected 1/a5", out_valid, out_data); end
        consume();
    endtask

    task automatic test_parity();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        n_checks++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL par_err: got %b expected 1", par_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL par_frame: got %b expected 0", frame_err); end
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL par_cnt: got %0d expected 1", err_cnt); end
        n_checks++; if ({o_par_err, o_out_data} !== {1'b0, 8'hA5}) begin n_fail++; $display("FAIL par_odd: got %b/%h expected 0/a5", o_par_err, o_out_data); end
        consume();
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL ferr_data: got %b/%h expected 1/3c", out_valid, out_data); end
        n_checks++; if ({par_err, frame_err} !== 2'b01) begin n_fail++; $display("FAIL ferr_flags: got %b expected 01", {par_err, frame_err}); end
        n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL ferr_cnt: got %0d expected 2", err_cnt); end
        consume();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %b expected 0", overrun); end
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b expected 1", overrun); end
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_keep: got %b/%h expected 1/11", out_valid, out_data); end
        n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL ovr_cnt: got %0d expected 3", err_cnt); end
        @(negedge clk);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_width: got %b expected 0", overrun); end
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL ovr_replace: got %b/%h expected 1/22", out_valid, out_data); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_none: got %b expected 0", overrun); end
        n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL ovr_cnt2: got %0d expected 3", err_cnt); end
        consume();
    endtask

    task automatic test_mid_reset();
        logic [10:0] f;
        f = frame_bits(8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(f[i], 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, err_cnt} !== {1'b0, 8'd0}) begin n_fail++; $display("FAIL mrst_async: got %b/%0d expected 0/0", busy, err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL mrst_data: got %b/%h expected 1/5a", out_valid, out_data); end
        n_checks++; if ({par_err, frame_err, err_cnt} !== 10'd0) begin n_fail++; $display("FAIL mrst_errs: got %b%b/%0d expected 00/0", par_err, frame_err, err_cnt); end
        consume();
    endtask

    // Continuous strobes: the start bit of frame 2 arrives the cycle right after stop of frame 1
    task automatic test_back_to_back();
        logic [21:0] s;
        s = {frame_bits(8'h7E, 1'b0, 1'b1), frame_bits(8'h81, 1'b0, 1'b1)};
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 11) begin
                n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h81}) begin n_fail++; $display("FAIL b2b_first: got %b/%h expected 1/81", out_valid, out_data); end
            end
            ser_in = s[i]; bit_en = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        bit_en = 1'b0; ser_in = 1'b1; out_ready = 1'b0;
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h7E}) begin n_fail++; $display("FAIL b2b_second: got %b/%h expected 1/7e", out_valid, out_data); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 0", err_cnt); end
        consume();
    endtask

    task automatic test_saturation();
        logic [10:0] f;
        for (int n = 0; n < 300; n++) send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 255", err_cnt); end
        n_checks++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL sat_par: got %b expected 1", par_err); end
        f = frame_bits(8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) send_bit(f[i], 1'b0);
        @(negedge clk);
        ser_in = 1'b1; bit_en = 1'b1; out_ready = 1'b1; clr_cnt = 1'b1;
        @(negedge clk);
        bit_en = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clr: got %0d expected 0", err_cnt); end
        n_checks++; if ({out_valid, par_err} !== 2'b11) begin n_fail++; $display("FAIL sat_last: got %b expected 11", {out_valid, par_err}); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity();
        test_frame_err();
        test_overrun();
        test_mid_reset();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
